int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_pkg.sv | 19 +
 rtl/int_prio_enc.sv | 29 ++
 rtl/int_ctrl.sv | 138 +++++++++++++
 tb/tb_int_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_pkg
// Description : Shared types and constants for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SRV  = 2'd2
    } state_t;

    localparam logic [9:0] c_vec_base   = 10'h3C0;
    localparam int         c_vec_stride = 4;

endpackage
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : int_prio_enc
// Description : Combinational priority encoder, lowest set index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module int_prio_enc #(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] i_req,
    output logic [IDW-1:0]  o_id,
    output logic            o_valid
);

    // Scanning downward lets the lowest index overwrite any higher one.
    always_comb begin
        o_id    = '0;
        o_valid = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id    = IDW'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Edge-triggered, non-nesting interrupt controller with vectors.
//               Define INT_SYNC_EN to add a two-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
    import int_pkg::*;
#(
    parameter int         NSRC     = 4,
    parameter logic [9:0] VEC_BASE = c_vec_base
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_in,
    input  logic            ack,
    input  logic            iret,
    output logic            irq,
    output logic [9:0]      vaddr,
    output logic [NSRC-1:0] pending,
    output logic            busy
);

    localparam int            c_idw = $clog2(NSRC);
    localparam logic [NSRC-1:0] c_one = {{(NSRC-1){1'b0}}, 1'b1};

    logic [NSRC-1:0]  w_src;
    logic [NSRC-1:0]  w_edge;
    logic [NSRC-1:0]  w_clr;
    logic [c_idw-1:0] w_win_id;
    logic             w_win_valid;
    logic [9:0]       w_vaddr_next;

    logic [NSRC-1:0]  r_src_q;
    logic [NSRC-1:0]  r_pending;
    logic [NSRC-1:0]  r_enable;
    state_t           r_state;
    logic [c_idw-1:0] r_cur_id;
    logic             r_irq;
    logic             r_busy;
    logic [9:0]       r_vaddr;

`ifdef INT_SYNC_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = src;
`endif

    assign w_edge = w_src ^ r_src_q;
    assign w_clr  = (r_state == REQ && ack) ? (c_one << r_cur_id) : '0;

    int_prio_enc #(
        .NSRC (NSRC),
        .IDW  (c_idw)
    ) u_prio (
        .i_req   (r_pending & r_enable),
        .o_id    (w_win_id),
        .o_valid (w_win_valid)
    );

    assign w_vaddr_next = VEC_BASE + 10'(w_win_id) * 10'(c_vec_stride);

    // A new edge on the serviced source outranks the acknowledge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_q   <= '0;
            r_pending <= '0;
            r_enable  <= '0;
        end else begin
            r_src_q   <= w_src;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we)
                r_enable <= mask_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cur_id <= '0;
            r_irq    <= 1'b0;
            r_busy   <= 1'b0;
            r_vaddr  <= VEC_BASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_state  <= REQ;
                        r_cur_id <= w_win_id;
                        r_vaddr  <= w_vaddr_next;
                        r_irq    <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        r_state <= SRV;
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SRV: begin
                    if (iret) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign irq     = r_irq;
    assign busy    = r_busy;
    assign vaddr   = r_vaddr;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Directed self-checking bench for int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

`ifdef INT_SYNC_EN
    localparam int c_extra = 2;
`else
    localparam int c_extra = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] src = 4'b0000;
    logic       mask_we = 1'b0;
    logic [3:0] mask_in = 4'b0000;
    logic       ack = 1'b0;
    logic       iret = 1'b0;
    logic       irq;
    logic [9:0] vaddr;
    logic [3:0] pending;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    int_ctrl #(
        .NSRC     (4),
        .VEC_BASE (10'h3C0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .ack     (ack),
        .iret    (iret),
        .irq     (irq),
        .vaddr   (vaddr),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_in = m;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_vaddr", vaddr, 10'h3C0);
        tick();
        tick();
        reset = 1'b0;

        // Single source, id 2
        write_mask(4'b1111);
        src[2] = 1'b1;
        repeat (c_extra) tick();
        chk("t1_pend_early", pending, 4'b0000);
        tick();
        chk("t1_pend", pending, 4'b0100);
        chk("t1_irq_early", irq, 0);
        tick();
        chk("t1_irq", irq, 1);
        chk("t1_vaddr", vaddr, 10'h3C8);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_irq_off", irq, 0);
        chk("t1_pend_clr", pending, 4'b0000);
        iret = 1'b1;
        tick();
        iret = 1'b0;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_irq", irq, 0);

        // Simultaneous sources 3 and 1: lower id first
        src = 4'b1110;
        repeat (c_extra + 1) tick();
        chk("t2_pend", pending, 4'b1010);
        tick();
        chk("t2_irq_a", irq, 1);
        chk("t2_vaddr_a", vaddr, 10'h3C4);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_pend_a", pending, 4'b1000);
        iret = 1'b1;
        tick();
        iret = 1'b0;
        chk("t2_irq_gap", irq, 0);
        tick();
        chk("t2_irq_b", irq, 1);
        chk("t2_vaddr_b", vaddr, 10'h3CC);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_pend_b", pending, 4'b0000);
        iret = 1'b1;
        tick();
        iret = 1'b0;

        // Masked source held until enabled
        write_mask(4'b0000);
        src[0] = 1'b1;
        repeat (c_extra + 1) tick();
        chk("t3_pend", pending, 4'b0001);
        tick();
        tick();
        chk("t3_irq_masked", irq, 0);
        chk("t3_pend_held", pending, 4'b0001);
        write_mask(4'b0001);
        chk("t3_irq_one_edge", irq, 0);
        tick();
        chk("t3_irq", irq, 1);
        chk("t3_vaddr", vaddr, 10'h3C0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        iret = 1'b1;
        tick();
        iret = 1'b0;

        // Edge on id 1 coincident with its acknowledge
        write_mask(4'b1111);
        src[1] = 1'b0;
        repeat (c_extra + 1) tick();
        tick();
        chk("t4_irq", irq, 1);
        chk("t4_vaddr", vaddr, 10'h3C4);
        ack = 1'b1;
        src[1] = 1'b1;
        tick();
        ack = 1'b0;
        repeat (c_extra) tick();
        chk("t4_pend_kept", pending, 4'b0010);
        chk("t4_busy", busy, 1);
        chk("t4_no_nest", irq, 0);
        iret = 1'b1;
        tick();
        iret = 1'b0;
        tick();
        chk("t4_irq_again", irq, 1);
        chk("t4_vaddr_again", vaddr, 10'h3C4);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t4_busy2", busy, 1);
        chk("t4_pend_clr", pending, 4'b0000);

        // Reset while in service with pending 1010
        src = 4'b0101;
        repeat (c_extra + 1) tick();
        chk("t5_pend", pending, 4'b1010);
        chk("t5_busy", busy, 1);
        chk("t5_no_nest", irq, 0);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_irq", irq, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_pending", pending, 4'b0000);
        chk("t5_rst_vaddr", vaddr, 10'h3C0);
        tick();
        reset = 1'b0;

        // Lines already high count as events after reset
        repeat (c_extra + 1) tick();
        chk("t6_pend", pending, 4'b0101);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t6_ack_ignored", busy, 0);
        iret = 1'b1;
        tick();
        iret = 1'b0;
        chk("t6_iret_ignored", busy, 0);
        chk("t6_irq_masked", irq, 0);
        write_mask(4'b0100);
        tick();
        chk("t6_irq", irq, 1);
        chk("t6_vaddr", vaddr, 10'h3C8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
